// File: rtl/sha3_xl_axil_slave_if.sv
// AXI4-Lite bundle between the block-design interconnect and the sha3_xl register slave.
interface sha3_xl_axil_slave_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   s00_axi_awaddr;
    logic [2:0]          s00_axi_awprot;
    logic                s00_axi_awvalid;
    logic                s00_axi_awready;
    logic [DATA_W-1:0]   s00_axi_wdata;
    logic [DATA_W/8-1:0] s00_axi_wstrb;
    logic                s00_axi_wvalid;
    logic                s00_axi_wready;
    logic [1:0]          s00_axi_bresp;
    logic                s00_axi_bvalid;
    logic                s00_axi_bready;
    logic [ADDR_W-1:0]   s00_axi_araddr;
    logic [2:0]          s00_axi_arprot;
    logic                s00_axi_arvalid;
    logic                s00_axi_arready;
    logic [DATA_W-1:0]   s00_axi_rdata;
    logic [1:0]          s00_axi_rresp;
    logic                s00_axi_rvalid;
    logic                s00_axi_rready;

    modport slave (
        input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        input  s00_axi_bready,
        input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
        input  s00_axi_rready,
        output s00_axi_awready, s00_axi_wready,
        output s00_axi_bresp, s00_axi_bvalid,
        output s00_axi_arready,
        output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
    );

    modport master (
        output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        output s00_axi_bready,
        output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
        output s00_axi_rready,
        input  s00_axi_awready, s00_axi_wready,
        input  s00_axi_bresp, s00_axi_bvalid,
        input  s00_axi_arready,
        input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
    );
endinterface

// File: rtl/sha3_xl_axil_slave.sv
// AXI4-Lite register slave for the sha3_xl core: four RW control registers with write
// strobes, plus live STATUS/DOUT readback. One outstanding write and one outstanding read.
module sha3_xl_axil_slave #(
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] REG_RESET          = '0
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_areset,
    sha3_xl_axil_slave_if.slave           s00_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
    output logic [3:0]                    reg_wr_pulse,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] core_status_i,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] core_dout_i
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e         wstate_q, wstate_d;
    rstate_e         rstate_q, rstate_d;
    logic            aw_held_q, aw_held_d;
    logic            w_held_q, w_held_d;
    logic [2:0]      waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic [DW-1:0]   regs_q [4];
    logic [DW-1:0]   regs_d [4];
    logic [3:0]      pulse_q, pulse_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            arready_q, arready_d;

    logic [AW-1:0]   awaddr_w, araddr_w;
    logic            aw_hs, w_hs, ar_hs;
    logic [2:0]      wsel;
    logic [DW-1:0]   wdin;
    logic [SW-1:0]   wstb;
    logic [2:0]      rsel;
    logic            unused_bits;

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] cur,
                                                 input logic [DW-1:0] din,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = cur;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) res[8*b +: 8] = din[8*b +: 8];
        end
        return res;
    endfunction

    assign awaddr_w = s00_axi.s00_axi_awaddr;
    assign araddr_w = s00_axi.s00_axi_araddr;
    assign unused_bits = ^{awaddr_w[1:0], araddr_w[1:0],
                           s00_axi.s00_axi_awprot, s00_axi.s00_axi_arprot};

    assign aw_hs = s00_axi.s00_axi_awvalid & awready_q;
    assign w_hs  = s00_axi.s00_axi_wvalid & wready_q;
    assign ar_hs = s00_axi.s00_axi_arvalid & arready_q;

    // A beat arriving this cycle is used directly so AW+W together commit in one edge.
    assign wsel = aw_hs ? awaddr_w[4:2] : waddr_q;
    assign wdin = w_hs ? s00_axi.s00_axi_wdata : wdata_q;
    assign wstb = w_hs ? s00_axi.s00_axi_wstrb : wstrb_q;
    assign rsel = araddr_w[4:2];

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        regs_d    = regs_q;
        pulse_d   = '0;

        case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    waddr_d   = awaddr_w[4:2];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s00_axi.s00_axi_wdata;
                    wstrb_d  = s00_axi.s00_axi_wstrb;
                end
                if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) begin
                    if (!wsel[2]) begin
                        regs_d[wsel[1:0]]  = apply_strb(regs_q[wsel[1:0]], wdin, wstb);
                        pulse_d[wsel[1:0]] = 1'b1;
                    end
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s00_axi.s00_axi_bready) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase

        awready_d = (wstate_d == W_IDLE) && !aw_held_d;
        wready_d  = (wstate_d == W_IDLE) && !w_held_d;
    end

    // Reads sample regs_q before any same-cycle write lands, giving pre-write data.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;

        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    if (!rsel[2]) begin
                        rdata_d = regs_q[rsel[1:0]];
                    end else begin
                        case (rsel[1:0])
                            2'd0:    rdata_d = core_status_i;
                            2'd1:    rdata_d = core_dout_i;
                            default: rdata_d = '0;
                        endcase
                    end
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s00_axi.s00_axi_rready) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase

        arready_d = (rstate_d == R_IDLE);
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            for (int k = 0; k < 4; k++) regs_q[k] <= REG_RESET;
            pulse_q   <= '0;
            rdata_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            for (int k = 0; k < 4; k++) regs_q[k] <= regs_d[k];
            pulse_q   <= pulse_d;
            rdata_q   <= rdata_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
        end
    end

    assign s00_axi.s00_axi_awready = awready_q;
    assign s00_axi.s00_axi_wready  = wready_q;
    assign s00_axi.s00_axi_bvalid  = (wstate_q == W_RESP);
    assign s00_axi.s00_axi_bresp   = 2'b00;
    assign s00_axi.s00_axi_arready = arready_q;
    assign s00_axi.s00_axi_rvalid  = (rstate_q == R_DATA);
    assign s00_axi.s00_axi_rdata   = rdata_q;
    assign s00_axi.s00_axi_rresp   = 2'b00;

    assign reg0_o       = regs_q[0];
    assign reg1_o       = regs_q[1];
    assign reg2_o       = regs_q[2];
    assign reg3_o       = regs_q[3];
    assign reg_wr_pulse = pulse_q;
endmodule

// File: tb/tb_sha3_xl_axil_slave.sv
// Bench for sha3_xl_axil_slave: directed protocol steps plus random traffic against a
// register-map model.
module tb_sha3_xl_axil_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [3:0]  pulse;
    logic [31:0] core_status, core_dout;

    int errors = 0;
    int checks = 0;

    logic [31:0] mregs [4];

    always #5 clk = ~clk;

    sha3_xl_axil_slave_if axi ();

    sha3_xl_axil_slave dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s00_axi        (axi),
        .reg0_o         (reg0),
        .reg1_o         (reg1),
        .reg2_o         (reg2),
        .reg3_o         (reg3),
        .reg_wr_pulse   (pulse),
        .core_status_i  (core_status),
        .core_dout_i    (core_dout)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_reg(input int k);
        case (k)
            0:       return reg0;
            1:       return reg1;
            2:       return reg2;
            default: return reg3;
        endcase
    endfunction

    // Spec rule: bytes with strobe 1 take new data, others keep the old value.
    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] nw,
                                                input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return (old & ~m) | (nw & m);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        int slot;
        slot = int'(a) / 4;
        if (slot < 4) return mregs[slot];
        if (slot == 4) return core_status;
        if (slot == 5) return core_dout;
        return 32'h0;
    endfunction

    task automatic send_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_done, w_done;
        axi.s00_axi_awaddr  = a;
        axi.s00_axi_awvalid = 1'b1;
        axi.s00_axi_wdata   = d;
        axi.s00_axi_wstrb   = s;
        axi.s00_axi_wvalid  = 1'b1;
        for (int i = 0; i < 40 && (axi.s00_axi_awvalid || axi.s00_axi_wvalid); i++) begin
            aw_done = axi.s00_axi_awvalid && axi.s00_axi_awready;
            w_done  = axi.s00_axi_wvalid && axi.s00_axi_wready;
            @(posedge clk); #1;
            if (aw_done) axi.s00_axi_awvalid = 1'b0;
            if (w_done)  axi.s00_axi_wvalid  = 1'b0;
        end
        check("wr_accept", {30'b0, axi.s00_axi_awvalid, axi.s00_axi_wvalid}, 32'h0);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int slot;
        logic [3:0] exp_pulse;
        slot = int'(a) / 4;
        send_write(a, d, s);
        exp_pulse = 4'b0;
        if (slot < 4) begin
            mregs[slot] = model_merge(mregs[slot], d, s);
            exp_pulse   = 4'(1 << slot);
        end
        check("wr_bvalid", axi.s00_axi_bvalid, 1);
        check("wr_bresp", axi.s00_axi_bresp, 0);
        check("wr_pulse", pulse, exp_pulse);
        if (slot < 4) check("wr_regout", dut_reg(slot), mregs[slot]);
        @(posedge clk); #1;
        check("wr_bdone", axi.s00_axi_bvalid, 0);
        check("wr_pulse_clr", pulse, 0);
        check("wr_awready_back", axi.s00_axi_awready, 1);
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] d);
        logic ar_done;
        axi.s00_axi_araddr  = a;
        axi.s00_axi_arvalid = 1'b1;
        for (int i = 0; i < 40 && axi.s00_axi_arvalid; i++) begin
            ar_done = axi.s00_axi_arready;
            @(posedge clk); #1;
            if (ar_done) axi.s00_axi_arvalid = 1'b0;
        end
        check("rd_accept", axi.s00_axi_arvalid, 0);
        check("rd_rvalid", axi.s00_axi_rvalid, 1);
        check("rd_rresp", axi.s00_axi_rresp, 0);
        d = axi.s00_axi_rdata;
        @(posedge clk); #1;
        check("rd_rdone", axi.s00_axi_rvalid, 0);
    endtask

    initial begin
        logic [31:0] rd, old, nw;
        logic [4:0]  a;
        logic [3:0]  s;

        rst = 1'b1;
        core_status = 32'h0;
        core_dout   = 32'h0;
        axi.s00_axi_awaddr = '0; axi.s00_axi_awprot = '0; axi.s00_axi_awvalid = 1'b0;
        axi.s00_axi_wdata  = '0; axi.s00_axi_wstrb  = '0; axi.s00_axi_wvalid  = 1'b0;
        axi.s00_axi_bready = 1'b1;
        axi.s00_axi_araddr = '0; axi.s00_axi_arprot = '0; axi.s00_axi_arvalid = 1'b0;
        axi.s00_axi_rready = 1'b1;
        for (int k = 0; k < 4; k++) mregs[k] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", axi.s00_axi_awready, 0);
        check("rst_wready", axi.s00_axi_wready, 0);
        check("rst_arready", axi.s00_axi_arready, 0);
        check("rst_bvalid", axi.s00_axi_bvalid, 0);
        check("rst_rvalid", axi.s00_axi_rvalid, 0);
        check("rst_rdata", axi.s00_axi_rdata, 0);
        check("rst_pulse", pulse, 0);
        for (int k = 0; k < 4; k++) check("rst_reg", dut_reg(k), 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_awready", axi.s00_axi_awready, 1);
        check("idle_arready", axi.s00_axi_arready, 1);

        // Sequential write then readback
        for (int k = 0; k < 4; k++) do_write(5'(4 * k), 32'(k + 1), 4'hF);
        for (int k = 0; k < 4; k++) begin
            do_read(5'(4 * k), rd);
            check("seq_read", rd, 32'(k + 1));
        end

        // W three cycles ahead of AW
        axi.s00_axi_wdata = 32'hDEADBEEF; axi.s00_axi_wstrb = 4'hF; axi.s00_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        axi.s00_axi_wvalid = 1'b0;
        check("wfirst_wready", axi.s00_axi_wready, 0);
        check("wfirst_awready", axi.s00_axi_awready, 1);
        repeat (2) @(posedge clk);
        #1;
        check("wfirst_nobvalid", axi.s00_axi_bvalid, 0);
        check("wfirst_reg1_old", reg1, mregs[1]);
        axi.s00_axi_awaddr = 5'h04; axi.s00_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        axi.s00_axi_awvalid = 1'b0;
        mregs[1] = 32'hDEADBEEF;
        check("wfirst_bvalid", axi.s00_axi_bvalid, 1);
        check("wfirst_reg1", reg1, 32'hDEADBEEF);
        check("wfirst_pulse", pulse, 4'b0010);
        @(posedge clk); #1;
        check("wfirst_wready_back", axi.s00_axi_wready, 1);

        // AW three cycles ahead of W
        axi.s00_axi_awaddr = 5'h04; axi.s00_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        axi.s00_axi_awvalid = 1'b0;
        check("awfirst_awready", axi.s00_axi_awready, 0);
        check("awfirst_wready", axi.s00_axi_wready, 1);
        repeat (2) @(posedge clk);
        #1;
        check("awfirst_nobvalid", axi.s00_axi_bvalid, 0);
        axi.s00_axi_wdata = 32'h0BADF00D; axi.s00_axi_wstrb = 4'hF; axi.s00_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        axi.s00_axi_wvalid = 1'b0;
        mregs[1] = 32'h0BADF00D;
        check("awfirst_bvalid", axi.s00_axi_bvalid, 1);
        check("awfirst_reg1", reg1, 32'h0BADF00D);
        @(posedge clk); #1;

        // Byte strobes, including an all-zero strobe
        do_write(5'h08, 32'h11223344, 4'hF);
        do_write(5'h08, 32'hAABBCCDD, 4'b0101);
        check("strb_reg2", reg2, 32'h11BB33DD);
        do_write(5'h08, 32'hFFFFFFFF, 4'b0000);
        check("strb0_reg2", reg2, 32'h11BB33DD);

        // Write response back-pressure
        axi.s00_axi_bready = 1'b0;
        send_write(5'h0C, 32'h600DCAFE, 4'hF);
        mregs[3] = 32'h600DCAFE;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", axi.s00_axi_bvalid, 1);
            check("bp_awready", axi.s00_axi_awready, 0);
            check("bp_wready", axi.s00_axi_wready, 0);
            @(posedge clk); #1;
        end
        axi.s00_axi_bready = 1'b1;
        @(posedge clk); #1;
        check("bp_bdone", axi.s00_axi_bvalid, 0);
        check("bp_awready_back", axi.s00_axi_awready, 1);

        // Read data back-pressure
        axi.s00_axi_rready = 1'b0;
        axi.s00_axi_araddr = 5'h08; axi.s00_axi_arvalid = 1'b1;
        @(posedge clk); #1;
        axi.s00_axi_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid", axi.s00_axi_rvalid, 1);
            check("bp_rdata", axi.s00_axi_rdata, mregs[2]);
            check("bp_arready", axi.s00_axi_arready, 0);
            @(posedge clk); #1;
        end
        axi.s00_axi_rready = 1'b1;
        @(posedge clk); #1;
        check("bp_rdone", axi.s00_axi_rvalid, 0);
        check("bp_arready_back", axi.s00_axi_arready, 1);

        // Read-only and reserved slots
        core_status = 32'hA5A50001;
        core_dout   = 32'h12345678;
        do_read(5'h10, rd); check("ro_status", rd, 32'hA5A50001);
        do_read(5'h14, rd); check("ro_dout", rd, 32'h12345678);
        do_read(5'h18, rd); check("ro_rsvd18", rd, 32'h0);
        do_read(5'h1F, rd); check("ro_rsvd1c", rd, 32'h0);
        do_write(5'h10, 32'hFFFFFFFF, 4'hF);
        do_read(5'h10, rd); check("ro_status_after_wr", rd, 32'hA5A50001);

        // Read and write of the same register accepted in the same cycle
        old = mregs[3];
        nw  = 32'h7E57C0DE;
        axi.s00_axi_awaddr = 5'h0C; axi.s00_axi_awvalid = 1'b1;
        axi.s00_axi_wdata  = nw; axi.s00_axi_wstrb = 4'hF; axi.s00_axi_wvalid = 1'b1;
        axi.s00_axi_araddr = 5'h0C; axi.s00_axi_arvalid = 1'b1;
        @(posedge clk); #1;
        axi.s00_axi_awvalid = 1'b0; axi.s00_axi_wvalid = 1'b0; axi.s00_axi_arvalid = 1'b0;
        mregs[3] = nw;
        check("coll_rvalid", axi.s00_axi_rvalid, 1);
        check("coll_rdata_old", axi.s00_axi_rdata, old);
        check("coll_reg3_new", reg3, nw);
        @(posedge clk); #1;
        do_read(5'h0C, rd); check("coll_read_new", rd, nw);

        // Random traffic, unaligned low address bits included
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    core_status = $urandom;
                    core_dout   = $urandom;
                    @(posedge clk); #1;
                end
                1: begin
                    a = 5'($urandom_range(0, 31));
                    s = 4'($urandom_range(0, 15));
                    do_write(a, $urandom, s);
                end
                default: begin
                    a = 5'($urandom_range(0, 31));
                    do_read(a, rd);
                    check("rand_read", rd, model_read(a));
                end
            endcase
        end

        // Reset while a write response is pending
        axi.s00_axi_bready = 1'b0;
        send_write(5'h00, 32'h55, 4'hF);
        check("rstmid_bvalid_before", axi.s00_axi_bvalid, 1);
        check("rstmid_reg0_before", reg0, 32'h55);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_bvalid", axi.s00_axi_bvalid, 0);
        check("rstmid_reg0", reg0, 32'h0);
        check("rstmid_awready", axi.s00_axi_awready, 0);
        rst = 1'b0;
        axi.s00_axi_bready = 1'b1;
        for (int k = 0; k < 4; k++) mregs[k] = 32'h0;
        @(posedge clk); #1;
        do_read(5'h00, rd); check("rstmid_read0", rd, 32'h0);
        do_read(5'h0C, rd); check("rstmid_read3", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
